// File: rtl/hex7seg_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// hex7seg_pkg : segment code table and counter width helper, rev 1.0
// ------------------------------------------------------------------
package hex7seg_pkg;

    // Active-high segment codes {a,b,c,d,e,f,g}, indexed by nibble value
    localparam logic [6:0] SEG_CODES [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hex7seg_scan_if.sv
`default_nettype none
// ------------------------------------------------------------------
// hex7seg_scan_if : load/data inputs and display drive outputs, rev 1.0
// ------------------------------------------------------------------
interface hex7seg_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] data;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   dig_en;
    logic                    frame;

    modport master (output load, data, blank_mask, input seg, dig_en, frame);
    modport slave  (input load, data, blank_mask, output seg, dig_en, frame);
endinterface
`default_nettype wire

// File: rtl/hex7seg_dec.sv
`default_nettype none
// ------------------------------------------------------------------
// hex7seg_dec : nibble to active-high 7-segment code, rev 1.0
// ------------------------------------------------------------------
module hex7seg_dec
    import hex7seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] code
);
    always_comb begin
        code = SEG_CODES[nibble];
    end
endmodule
`default_nettype wire

// File: rtl/hex7seg_scan.sv
`default_nettype none
// ------------------------------------------------------------------
// hex7seg_scan : time-multiplexed hex display scanner, rev 1.0
// ------------------------------------------------------------------
module hex7seg_scan
    import hex7seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int ACTIVE_LOW = 0
) (
    input  logic          clk,
    input  logic          rst,
    hex7seg_scan_if.slave bus
);
    localparam int PW = cnt_width(SCAN_DIV);
    localparam int IW = cnt_width(NUM_DIGITS);
    localparam logic [6:0]            SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                  : {NUM_DIGITS{1'b0}};

    logic [PW-1:0]           prescale;
    logic [IW-1:0]           idx;
    logic                    tc;
    logic                    idx_last;
    logic                    frame_reg;
    logic [4*NUM_DIGITS-1:0] shadow_data;
    logic [NUM_DIGITS-1:0]   shadow_blank;
    logic [3:0]              nibble;
    logic [6:0]              code;
    logic                    blank_sel;
    logic [6:0]              seg_reg;
    logic [NUM_DIGITS-1:0]   dig_reg;

    always_comb begin
        tc        = (prescale == PW'(SCAN_DIV - 1));
        idx_last  = (idx == IW'(NUM_DIGITS - 1));
        nibble    = shadow_data[4*idx +: 4];
        blank_sel = shadow_blank[idx];
    end

    // Load never touches the prescaler or idx, so scan timing is independent of updates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale  <= '0;
            idx       <= '0;
            frame_reg <= 1'b0;
        end else begin
            prescale  <= tc ? '0 : prescale + 1'b1;
            frame_reg <= tc & idx_last;
            if (tc) begin
                idx <= idx_last ? '0 : idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_data  <= '0;
            shadow_blank <= '0;
        end else if (bus.load) begin
            shadow_data  <= bus.data;
            shadow_blank <= bus.blank_mask;
        end
    end

    hex7seg_dec u_dec (
        .nibble (nibble),
        .code   (code)
    );

    // Polarity is folded into the output registers so the pins never glitch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_reg <= SEG_OFF;
            dig_reg <= DIG_OFF;
        end else begin
            seg_reg <= (blank_sel ? 7'h00 : code) ^ SEG_OFF;
            dig_reg <= (NUM_DIGITS'(1) << idx) ^ DIG_OFF;
        end
    end

    assign bus.seg    = seg_reg;
    assign bus.dig_en = dig_reg;
    assign bus.frame  = frame_reg;

endmodule
`default_nettype wire

// File: tb/tb_hex7seg_scan.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_hex7seg_scan : scoreboard bench for two display configurations, rev 1.0
// ------------------------------------------------------------------
module tb_hex7seg_scan;

    typedef struct packed {
        logic [6:0] seg;
        logic [7:0] dig;
        logic       frame;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  blank = '0;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   k        = 0;
    exp_t qa[$];
    exp_t qb[$];
    logic [31:0] sh_data  = '0;
    logic [7:0]  sh_blank = '0;

    logic [6:0] code_tbl [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    hex7seg_scan_if #(.NUM_DIGITS(4)) bus_a ();
    hex7seg_scan_if #(.NUM_DIGITS(1)) bus_b ();

    assign bus_a.load       = load;
    assign bus_a.data       = data;
    assign bus_a.blank_mask = blank;
    assign bus_b.load       = load;
    assign bus_b.data       = data[3:0];
    assign bus_b.blank_mask = blank[0];

    hex7seg_scan #(.NUM_DIGITS(4), .SCAN_DIV(3), .ACTIVE_LOW(0)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a.slave)
    );
    hex7seg_scan #(.NUM_DIGITS(1), .SCAN_DIV(1), .ACTIVE_LOW(1)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b.slave)
    );

    always #5 clk = ~clk;

    function automatic exp_t reset_exp(input bit al, input int nd);
        exp_t e;
        e.seg   = al ? 7'h7F : 7'h00;
        e.dig   = al ? 8'((1 << nd) - 1) : 8'h00;
        e.frame = 1'b0;
        return e;
    endfunction

    // Output after the k-th edge since reset release, from the shadow held before that edge
    function automatic exp_t predict(input int kk, input int nd, input int sd, input bit al,
                                     input logic [31:0] sdata, input logic [7:0] sblank);
        exp_t e;
        int   di;
        di      = ((kk - 1) / sd) % nd;
        e.seg   = sblank[di] ? 7'h00 : code_tbl[sdata[4*di +: 4]];
        e.dig   = 8'(1 << di);
        e.frame = (kk % (sd * nd)) == 0;
        if (al) begin
            e.seg = ~e.seg;
            e.dig = ~e.dig & 8'((1 << nd) - 1);
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Predictor: pushes the expected outputs of every edge, then applies any load
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                k        = 0;
                sh_data  = '0;
                sh_blank = '0;
                qa.push_back(reset_exp(1'b0, 4));
                qb.push_back(reset_exp(1'b1, 1));
            end else begin
                k++;
                qa.push_back(predict(k, 4, 3, 1'b0, sh_data, sh_blank));
                qb.push_back(predict(k, 1, 1, 1'b1, sh_data, sh_blank));
                if (load) begin
                    sh_data  = {16'h0, data};
                    sh_blank = {4'h0, blank};
                end
            end
        end
    end

    // Monitor: the display presents a new value every cycle, compared mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (qa.size() > 0) begin
                e = qa.pop_front();
                check("a_seg",   32'(bus_a.seg),    32'(e.seg));
                check("a_dig",   32'(bus_a.dig_en), 32'(e.dig));
                check("a_frame", 32'(bus_a.frame),  32'(e.frame));
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                check("b_seg",   32'(bus_b.seg),    32'(e.seg));
                check("b_dig",   32'(bus_b.dig_en), 32'(e.dig));
                check("b_frame", 32'(bus_b.frame),  32'(e.frame));
            end
        end
    end

    task automatic do_load(input logic [15:0] d, input logic [3:0] b);
        @(posedge clk); #1;
        load  = 1'b1;
        data  = d;
        blank = b;
        @(posedge clk); #1;
        load  = 1'b0;
    endtask

    initial begin
        int guard;
        repeat (3) @(posedge clk);
        @(negedge clk); #1 rst = 1'b0;
        repeat (4) @(posedge clk);

        do_load(16'hB41D, 4'b0000);
        repeat (30) @(posedge clk);

        for (int n = 0; n < 16; n++) begin
            do_load({12'($urandom), 4'(n)}, 4'b0000);
            repeat (12) @(posedge clk);
        end

        do_load(16'($urandom), 4'b0100);
        repeat (26) @(posedge clk);

        // Loads landing exactly on a terminal-count edge
        for (int t = 0; t < 8; t++) begin
            guard = 0;
            do begin
                @(posedge clk); #1;
                guard++;
            end while (((k + 1) % 3) != 0 && guard < 4);
            load  = 1'b1;
            data  = 16'($urandom);
            blank = 4'($urandom);
            @(posedge clk); #1;
            load  = 1'b0;
            repeat (guard % 3) @(posedge clk);
        end

        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            load  = ($urandom_range(0, 3) == 0);
            data  = 16'($urandom);
            blank = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
        end
        @(posedge clk); #1 load = 1'b0;

        // Asynchronous reset between edges: outputs must clear with no clock
        repeat (4) @(posedge clk);
        @(negedge clk); #1 rst = 1'b1;
        #1;
        check("rst_a_seg",   32'(bus_a.seg),    32'h00);
        check("rst_a_dig",   32'(bus_a.dig_en), 32'h0);
        check("rst_a_frame", 32'(bus_a.frame),  32'h0);
        check("rst_b_seg",   32'(bus_b.seg),    32'h7F);
        check("rst_b_dig",   32'(bus_b.dig_en), 32'h1);
        repeat (2) @(posedge clk);
        @(negedge clk); #1 rst = 1'b0;
        repeat (30) @(posedge clk);

        @(negedge clk); #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hex7seg_scan.md
HEX7SEG_SCAN -- requirements
Module: hex7seg_scan

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits, legal range 1..8.
REQ-002 The block SHALL have parameter SCAN_DIV, default 1000, clock cycles each digit is lit, legal range 1..2^20.
REQ-003 The block SHALL have parameter ACTIVE_LOW, default 0; when 1, seg and dig_en are inverted at the output registers.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 load  input  1  capture data and blank_mask into the shadow registers on this edge.
REQ-008 data  input  4*NUM_DIGITS  hex nibbles; digit i is data[4i+3:4i].
REQ-009 blank_mask  input  NUM_DIGITS  bit i set forces digit i dark.
REQ-010 seg  output  7  segment drive {a,b,c,d,e,f,g}, with a as the MSB.
REQ-011 dig_en  output  NUM_DIGITS  one-hot digit enable.
REQ-012 frame  output  1  one-cycle pulse when the scan wraps from the last digit to digit 0.

Function
REQ-013 Segment codes (active-high, a..g) SHALL be: 0:7E 1:30 2:6D 3:79 4:33 5:5B 6:5F 7:70 8:7F 9:7B A:77 b:1F C:4E d:3D E:4F F:47.
REQ-014 Segment a SHALL therefore be off only for nibbles 1, 4, B and D.
REQ-015 A prescaler SHALL count 0..SCAN_DIV-1 and wrap to 0; its terminal count is called tc.
REQ-016 Index idx SHALL advance by 1 on tc and wrap from NUM_DIGITS-1 to 0.
REQ-017 With NUM_DIGITS=1, idx SHALL stay at 0.
REQ-018 With SCAN_DIV=1, tc SHALL assert every cycle.
REQ-019 frame SHALL be registered and assert for one cycle on the edge where idx wraps to 0; with NUM_DIGITS=1 it SHALL pulse on every tc.
REQ-020 On load, shadow_data and shadow_blank SHALL update at that edge; at all other times they hold.
REQ-021 seg and dig_en SHALL be registered from the current idx and shadow values, giving a latency of exactly 1 cycle after an idx or shadow change.
REQ-022 seg and dig_en SHALL always update on the same edge.
REQ-023 If shadow_blank[idx] is set, seg SHALL be all-off while dig_en still selects idx.
REQ-024 A load on the same edge as tc SHALL have both updates take effect together; the next output update uses the new idx and the new shadow.
REQ-025 load SHALL NOT reset the prescaler or idx, so the scan timing is unaffected.

Reset
REQ-026 While rst is high, prescaler, idx and frame SHALL be 0, shadow_data and shadow_blank SHALL be 0, and seg and dig_en SHALL be all-off (all-ones when ACTIVE_LOW=1).
REQ-027 Reset asserted mid-scan SHALL clear all state immediately, without waiting for a clock.
REQ-028 On the first edge after reset release, the outputs SHALL be seg=7E and dig_en=one-hot bit 0.

Structure
REQ-029 Package hex7seg_pkg SHALL hold the 16-entry segment code constant table and a width helper for the prescaler and idx.
REQ-030 One combinational sub-module, hex7seg_dec (nibble to 7-bit code), SHALL be instantiated once on the selected nibble.

Verification
REQ-031 Scenario: NUM_DIGITS=4, SCAN_DIV=3, load data=16'hB41D, blank=0 -> seg sequence per digit 3F(D... i.e. digit0 D:3D), digit1 1:30, digit2 4:33, digit3 B:1F; each held 3 cycles; frame pulses every 12 cycles.
REQ-032 Scenario: sweep nibbles 0..F on digit 0 -> seg matches the REQ-013 table; bit a is 0 only for 1, 4, B and D.
REQ-033 Scenario: blank_mask=4'b0100 -> seg=00 while dig_en=0100, and the other digits are unaffected.
REQ-034 Scenario: load asserted on a tc edge with a new value -> the next output update shows the new nibble for the new idx.
REQ-035 Scenario: assert rst mid-digit -> seg=00, dig_en=0 and frame=0 with no clock; after release, the first edge gives seg=7E, dig_en=0001.
REQ-036 Scenario: ACTIVE_LOW=1, NUM_DIGITS=1, SCAN_DIV=1 -> seg is the inverted code, dig_en stays 0, and frame is high every cycle after the first.
